// File: rtl/kbd_pkg.sv
// Shared keyboard-path constants: FIFO geometry and the port addresses
// decoded by the port controller.
package kbd_pkg;

  localparam int KBD_DEPTH_LOG2 = 4;
  localparam int KBD_DEPTH      = 1 << KBD_DEPTH_LOG2;

  localparam logic [15:0] KBD_PORT_DATA = 16'h0060;
  localparam logic [15:0] KBD_PORT_STAT = 16'h0064;

endpackage

// File: rtl/kbd_fifo_mem.sv
// Scancode storage: register array with one synchronous write port and one
// asynchronous read port.
module kbd_fifo_mem
  import kbd_pkg::*;
#(
  parameter int AW = KBD_DEPTH_LOG2,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO: edge-qualified capture of PS/2 bytes, head-of-queue
// presentation for port reads, sticky overflow and level IRQ1 request.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH_LOG2     = KBD_DEPTH_LOG2,
  parameter int FLUSH_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_hit,
  input  logic                rd,
  input  logic                clr,
  input  logic                irq_en,
  output logic [7:0]          data_o,
  output logic                ready,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                irq
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  localparam logic                FLUSH_RST  = (FLUSH_ON_RESET != 0);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  hit_q;
  logic [7:0]            rdata;
  logic                  hold_off;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic                  push_req;
  logic                  pop_ok;
  logic                  push_ok;

  // Any cycle with reset or clr discards the push/pop presented with it.
  assign hold_off = reset | clr;
  assign flush    = clr | (reset & FLUSH_RST);
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push_req = ps2_hit & ~hit_q & ~hold_off;
  assign pop_ok   = rd & ~empty & ~hold_off;
  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  assign push_ok  = push_req & (~full | pop_ok);

  always_ff @(posedge clock) begin
    if (hold_off) hit_q <= 1'b0;
    else          hit_q <= ps2_hit;

    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  kbd_fifo_mem #(
    .AW(DEPTH_LOG2),
    .DW(8)
  ) u_mem (
    .clock(clock),
    .we   (push_ok),
    .waddr(wr_ptr),
    .wdata(ps2_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  assign data_o = empty ? 8'h00 : rdata;
  assign ready  = ~empty;
  assign irq    = ready & irq_en;

endmodule

// File: tb/tb_kbd_fifo.sv
// Scoreboard bench for kbd_fifo: a queue-based reference model predicts status
// every cycle and the byte each pop should return; a monitor checks pops.
module tb_kbd_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ps2_data;
  logic       ps2_hit;
  logic       rd;
  logic       clr;
  logic       irq_en;
  logic [7:0] data_o;
  logic       ready;
  logic [4:0] count;
  logic       overflow;
  logic       irq;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         model_ovf;
  bit         model_prev;
  int         checks = 0;
  int         fails  = 0;

  kbd_fifo #(
    .DEPTH_LOG2(4),
    .FLUSH_ON_RESET(1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_data(ps2_data),
    .ps2_hit (ps2_hit),
    .rd      (rd),
    .clr     (clr),
    .irq_en  (irq_en),
    .data_o  (data_o),
    .ready   (ready),
    .count   (count),
    .overflow(overflow),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare all status outputs against the model state of the current cycle.
  task automatic checkOutput();
    int head;
    head = (model_q.size() > 0) ? int'(model_q[0]) : 0;
    checkValue("count", int'(count), model_q.size());
    checkValue("ready", int'(ready), int'(model_q.size() > 0));
    checkValue("irq", int'(irq), int'(model_q.size() > 0 && irq_en));
    checkValue("overflow", int'(overflow), int'(model_ovf));
    checkValue("data_o", int'(data_o), head);
  endtask

  // One clock cycle of stimulus; the model commits its state after the edge.
  task automatic applyStimulus(input bit hit, input logic [7:0] data, input bit rd_i,
                               input bit clr_i, input bit rst_i);
    bit req, pop_now, push_now;
    ps2_hit  = hit;
    ps2_data = data;
    rd       = rd_i;
    clr      = clr_i;
    reset    = rst_i;
    req      = hit && !model_prev && !rst_i && !clr_i;
    pop_now  = rd_i && !rst_i && !clr_i && (model_q.size() > 0);
    push_now = req && ((model_q.size() < 16) || pop_now);
    if (pop_now) exp_q.push_back(model_q[0]);
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    #1;
    if (rst_i || clr_i) begin
      model_q.delete();
      model_ovf  = 1'b0;
      model_prev = 1'b0;
    end else begin
      if (pop_now) void'(model_q.pop_front());
      if (push_now) model_q.push_back(data);
      if (req && !push_now) model_ovf = 1'b1;
      model_prev = hit;
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popByte();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: every effective read must return the next byte the model predicted.
  always @(negedge clock) begin
    if (rd && ready && !reset && !clr) begin
      if (exp_q.size() == 0) begin
        checkValue("unexpected_pop", int'(data_o), -1);
      end else begin
        checkValue("pop_data", int'(data_o), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bit hit_r;
    int rd_pct;
    reset    = 1'b1;
    ps2_hit  = 1'b0;
    ps2_data = 8'h00;
    rd       = 1'b0;
    clr      = 1'b0;
    irq_en   = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_q.delete();
    model_ovf  = 1'b0;
    model_prev = 1'b0;
    checkValue("reset_count", int'(count), 0);
    checkValue("reset_data", int'(data_o), 0);

    $display("[TB] single held strobe");
    repeat (3) applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("t1_count", int'(count), 1);
    checkValue("t1_data", int'(data_o), 8'h1C);
    checkValue("t1_irq", int'(irq), 1);
    popByte();
    checkValue("t1_count_after_rd", int'(count), 0);
    checkValue("t1_data_after_rd", int'(data_o), 0);
    checkValue("t1_irq_after_rd", int'(irq), 0);

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 16; i++) pushByte(8'(i));
    pushByte(8'hAA);
    checkValue("t2_count", int'(count), 16);
    checkValue("t2_overflow", int'(overflow), 1);
    for (int i = 0; i < 16; i++) popByte();
    checkValue("t2_drained", int'(count), 0);
    checkValue("t2_overflow_sticky", int'(overflow), 1);

    $display("[TB] clr and reset while strobe rises");
    for (int i = 0; i < 3; i++) pushByte(8'h40 + 8'(i));
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("t6_clr_count", int'(count), 0);
    checkValue("t6_clr_overflow", int'(overflow), 0);
    pushByte(8'h61);
    pushByte(8'h62);
    applyStimulus(1'b1, 8'h98, 1'b0, 1'b0, 1'b1);
    checkValue("t6_rst_count", int'(count), 0);
    applyStimulus(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("t6_post_rst_push", int'(count), 1);
    checkValue("t6_post_rst_data", int'(data_o), 8'h5B);
    popByte();

    $display("[TB] push and pop on full");
    for (int i = 0; i < 16; i++) pushByte(8'h20 + 8'(i));
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("t3_count", int'(count), 16);
    checkValue("t3_overflow", int'(overflow), 0);
    for (int i = 0; i < 15; i++) popByte();
    checkValue("t3_last_entry", int'(data_o), 8'h55);
    popByte();

    $display("[TB] push and pop on empty");
    applyStimulus(1'b1, 8'h3A, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("t4_count", int'(count), 1);
    checkValue("t4_data", int'(data_o), 8'h3A);
    popByte();
    popByte();
    checkValue("t4_empty_rd", int'(count), 0);
    pushByte(8'h77);
    checkValue("t4_after_empty_rd", int'(data_o), 8'h77);
    popByte();

    $display("[TB] wrap-around");
    for (int i = 0; i < 10; i++) pushByte(8'h80 + 8'(i));
    for (int i = 0; i < 10; i++) popByte();
    for (int i = 0; i < 10; i++) pushByte(8'hB0 + 8'(i));
    for (int i = 0; i < 10; i++) popByte();

    $display("[TB] interrupt disabled");
    irq_en = 1'b0;
    pushByte(8'h2E);
    checkValue("t6_irq_masked", int'(irq), 0);
    checkValue("t6_ready_masked", int'(ready), 1);
    popByte();
    irq_en = 1'b1;

    $display("[TB] randomized traffic");
    hit_r  = 1'b0;
    rd_pct = 30;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) rd_pct = int'($urandom_range(10, 70));
      if (i % 50 == 0) irq_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 45) hit_r = ~hit_r;
      applyStimulus(hit_r, 8'($urandom), $urandom_range(0, 99) < rd_pct,
                    $urandom_range(0, 199) == 0, $urandom_range(0, 249) == 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
